// File: rtl/pio_bank_irq.sv
`default_nettype none
// ============================================================================
//  Module   : pio_bank_irq
//  Purpose  : Bank of CHANNELS bidirectional PIO channels (WIDTH bits each)
//             behind one Avalon-MM slave, with per-channel input
//             synchroniser, sticky edge capture, interrupt mask and output
//             register, plus a single registered level interrupt.
//
//  Ports    : clk_clk        - single clock for all logic
//             reset_reset_n  - asynchronous active-low reset
//             avs_address    - word address (channel c at 4*c, PEND at 4*CHANNELS)
//             avs_read       - read strobe
//             avs_write      - write strobe
//             avs_writedata  - write data (bits above WIDTH ignored)
//             avs_readdata   - registered read data, latency 1, 0 when idle
//             in_port        - asynchronous inputs, channel c at [c*WIDTH +: WIDTH]
//             out_port       - output registers, same packing
//             irq            - level interrupt, active high
//
//  Register map per channel c (base 4*c):
//             +0 DATA (RO)  +1 OUT (RW)  +2 EDGE (R / W1C)  +3 MASK (RW)
//             4*CHANNELS PEND: R bit c = |(EDGE_c & MASK_c), W bit c clears EDGE_c
//
//  Revision : 1.0  initial release
// ============================================================================
module pio_bank_irq #(
    parameter int              CHANNELS  = 4,
    parameter int              WIDTH     = 8,
    parameter int              ADDR_W    = 5,
    parameter int              EDGE_TYPE = 0,
    parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic [ADDR_W-1:0]           avs_address,
    input  logic                        avs_read,
    input  logic                        avs_write,
    input  logic [31:0]                 avs_writedata,
    output logic [31:0]                 avs_readdata,
    input  logic [CHANNELS*WIDTH-1:0]   in_port,
    output logic [CHANNELS*WIDTH-1:0]   out_port,
    output logic                        irq
);

    localparam int c_PEND_ADDR = 4 * CHANNELS;

    // Channel-major packed storage: element c sits at [c*WIDTH +: WIDTH]
    // when flattened, matching the in_port/out_port packing directly.
    logic [CHANNELS-1:0][WIDTH-1:0] r_s1;
    logic [CHANNELS-1:0][WIDTH-1:0] r_s2;
    logic [CHANNELS-1:0][WIDTH-1:0] r_prev;
    logic [CHANNELS-1:0][WIDTH-1:0] r_edge;
    logic [CHANNELS-1:0][WIDTH-1:0] r_mask;
    logic [CHANNELS-1:0][WIDTH-1:0] r_out;
    logic [31:0]                    r_rdata;
    logic                           r_irq;

    logic [CHANNELS-1:0][WIDTH-1:0] w_det;
    logic [CHANNELS-1:0][WIDTH-1:0] w_clr;
    logic [CHANNELS-1:0]            w_out_we;
    logic [CHANNELS-1:0]            w_edge_we;
    logic [CHANNELS-1:0]            w_mask_we;
    logic                           w_pend_we;
    logic [CHANNELS-1:0]            w_pend;
    logic [WIDTH-1:0]               w_wdata;
    logic [31:0]                    w_rdata;
    logic                           w_unused;

    assign w_wdata = avs_writedata[WIDTH-1:0];

    // Write-data bits above WIDTH (and above CHANNELS for PEND) carry no meaning.
    assign w_unused = &{1'b0, avs_writedata};

    // ------------------------------------------------------------------
    // Edge detector selected at elaboration time
    // ------------------------------------------------------------------
    generate
        if (EDGE_TYPE == 1) begin : g_rise
            assign w_det = r_s2 & ~r_prev;
        end else if (EDGE_TYPE == 2) begin : g_fall
            assign w_det = ~r_s2 & r_prev;
        end else begin : g_any
            assign w_det = r_s2 ^ r_prev;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Address decode for writes, and per-channel edge clear masks.
    // EDGE W1C and PEND clear never coincide on one channel since only
    // one address is presented per cycle; OR-ing them is still safe.
    // ------------------------------------------------------------------
    always_comb begin
        w_out_we  = '0;
        w_edge_we = '0;
        w_mask_we = '0;
        w_clr     = '0;
        w_pend_we = avs_write && (avs_address == ADDR_W'(c_PEND_ADDR));
        for (int c = 0; c < CHANNELS; c++) begin
            w_out_we[c]  = avs_write && (avs_address == ADDR_W'(4 * c + 1));
            w_edge_we[c] = avs_write && (avs_address == ADDR_W'(4 * c + 2));
            w_mask_we[c] = avs_write && (avs_address == ADDR_W'(4 * c + 3));
            w_clr[c]     = (w_edge_we[c] ? w_wdata : '0)
                         | {WIDTH{w_pend_we & avs_writedata[c]}};
        end
    end

    // Per-channel pending flag, shared by PEND reads and the interrupt.
    always_comb begin
        w_pend = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_pend[c] = |(r_edge[c] & r_mask[c]);
        end
    end

    // ------------------------------------------------------------------
    // Read mux from current (pre-write) register state; unmapped reads 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (avs_address == ADDR_W'(4 * c))     w_rdata[WIDTH-1:0] = r_s2[c];
            if (avs_address == ADDR_W'(4 * c + 1)) w_rdata[WIDTH-1:0] = r_out[c];
            if (avs_address == ADDR_W'(4 * c + 2)) w_rdata[WIDTH-1:0] = r_edge[c];
            if (avs_address == ADDR_W'(4 * c + 3)) w_rdata[WIDTH-1:0] = r_mask[c];
        end
        if (avs_address == ADDR_W'(c_PEND_ADDR)) begin
            w_rdata[CHANNELS-1:0] = w_pend;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_prev  <= '0;
            r_edge  <= '0;
            r_mask  <= '0;
            r_out   <= {CHANNELS{OUT_RESET}};
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_s1    <= in_port;
            r_s2    <= r_s1;
            r_prev  <= r_s2;
            r_rdata <= avs_read ? w_rdata : 32'd0;
            r_irq   <= |w_pend;
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_out_we[c])  r_out[c]  <= w_wdata;
                if (w_mask_we[c]) r_mask[c] <= w_wdata;
                // Detect is OR-ed after the clear so a same-cycle edge wins.
                r_edge[c] <= (r_edge[c] & ~w_clr[c]) | w_det[c];
            end
        end
    end

    assign out_port     = r_out;
    assign avs_readdata = r_rdata;
    assign irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_pio_bank_irq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pio_bank_irq
//  Purpose  : Self-checking bench for pio_bank_irq. Three instances share all
//             stimulus and differ only in EDGE_TYPE (0 any, 1 rise, 2 fall).
//             A behavioural model tracks the register map; every cycle the
//             outputs of all instances are compared against it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pio_bank_irq;

    localparam int NK = 3;

    logic        clk;
    logic        reset_reset_n;
    logic [4:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] in_port;
    logic [31:0] rdata [NK];
    logic [31:0] outp  [NK];
    logic        irq_o [NK];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < NK; k++) begin : g_dut
        pio_bank_irq #(
            .CHANNELS (4),
            .WIDTH    (8),
            .ADDR_W   (5),
            .EDGE_TYPE(k),
            .OUT_RESET(8'hA5)
        ) u_dut (
            .clk_clk      (clk),
            .reset_reset_n(reset_reset_n),
            .avs_address  (avs_address),
            .avs_read     (avs_read),
            .avs_write    (avs_write),
            .avs_writedata(avs_writedata),
            .avs_readdata (rdata[k]),
            .in_port      (in_port),
            .out_port     (outp[k]),
            .irq          (irq_o[k])
        );
    end

    // ------------------------------------------------------------------
    // Behavioural model
    // m_smp[0] = newest sample of in_port, m_smp[1] = synchronised value,
    // m_smp[2] = the synchronised value one cycle earlier.
    // ------------------------------------------------------------------
    logic [31:0] m_smp  [3];
    logic [7:0]  m_edge [NK][4];
    logic [7:0]  m_mask [NK][4];
    logic [7:0]  m_out  [NK][4];
    logic [31:0] m_rd   [NK];
    logic        m_irq  [NK];

    function automatic logic [3:0] m_pend(input int k);
        logic [3:0] p;
        for (int c = 0; c < 4; c++) p[c] = |(m_edge[k][c] & m_mask[k][c]);
        return p;
    endfunction

    function automatic logic [31:0] m_read(input int k, input int a);
        logic [31:0] v;
        v = 32'd0;
        if (a < 16) begin
            case (a % 4)
                0: v = {24'd0, m_smp[1][(a/4)*8 +: 8]};
                1: v = {24'd0, m_out[k][a/4]};
                2: v = {24'd0, m_edge[k][a/4]};
                default: v = {24'd0, m_mask[k][a/4]};
            endcase
        end else if (a == 16) begin
            v = {28'd0, m_pend(k)};
        end
        return v;
    endfunction

    function automatic logic [31:0] m_outword(input int k);
        return {m_out[k][3], m_out[k][2], m_out[k][1], m_out[k][0]};
    endfunction

    always @(posedge clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < 3; i++) m_smp[i] = 32'd0;
            for (int k = 0; k < NK; k++) begin
                m_rd[k]  = 32'd0;
                m_irq[k] = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    m_edge[k][c] = 8'd0;
                    m_mask[k][c] = 8'd0;
                    m_out[k][c]  = 8'hA5;
                end
            end
        end else begin
            for (int k = 0; k < NK; k++) begin
                logic [31:0] det;
                int a;
                a = int'(avs_address);
                // Outputs computed from state before this edge.
                m_rd[k]  = avs_read ? m_read(k, a) : 32'd0;
                m_irq[k] = |m_pend(k);
                case (k)
                    0: det = m_smp[1] ^ m_smp[2];
                    1: det = m_smp[1] & ~m_smp[2];
                    default: det = ~m_smp[1] & m_smp[2];
                endcase
                for (int c = 0; c < 4; c++) begin
                    logic [7:0] clr;
                    clr = 8'd0;
                    if (avs_write && a == 4*c + 2) clr = avs_writedata[7:0];
                    if (avs_write && a == 16 && avs_writedata[c]) clr = 8'hFF;
                    m_edge[k][c] = (m_edge[k][c] & ~clr) | det[c*8 +: 8];
                end
                if (avs_write && a < 16 && (a % 4) == 1) m_out[k][a/4]  = avs_writedata[7:0];
                if (avs_write && a < 16 && (a % 4) == 3) m_mask[k][a/4] = avs_writedata[7:0];
            end
            m_smp[2] = m_smp[1];
            m_smp[1] = m_smp[0];
            m_smp[0] = in_port;
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #2;
        for (int k = 0; k < NK; k++) begin
            check($sformatf("model rdata[%0d]", k), rdata[k], m_rd[k]);
            check($sformatf("model irq[%0d]", k), {31'd0, irq_o[k]}, {31'd0, m_irq[k]});
            check($sformatf("model out_port[%0d]", k), outp[k], m_outword(k));
        end
    end

    task automatic cyc(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_read      = r;
        avs_write     = w;
        avs_address   = a;
        avs_writedata = d;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    // Issue a read and stop just after the edge that returns its data.
    task automatic rd(input logic [4:0] a);
        cyc(1'b1, 1'b0, a, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [4:0] regs [8];
        regs = '{5'd2, 5'd3, 5'd6, 5'd7, 5'd10, 5'd11, 5'd14, 5'd15};

        reset_reset_n = 1'b0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_address   = 5'd0;
        avs_writedata = 32'd0;
        in_port       = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NK; k++) begin
            check("reset out_port", outp[k], 32'hA5A5A5A5);
            check("reset irq", {31'd0, irq_o[k]}, 32'd0);
            check("reset rdata", rdata[k], 32'd0);
        end
        @(negedge clk);
        reset_reset_n = 1'b1;

        // EDGE and MASK read back as zero after reset
        for (int i = 0; i < 8; i++) begin
            rd(regs[i]);
            check("post-reset EDGE/MASK", rdata[1], 32'd0);
        end

        // ch1 OUT write: visible from the sampling edge, others unchanged
        cyc(1'b0, 1'b1, 5'd5, 32'hFFFF_FF3C);
        @(posedge clk);
        #1;
        check("OUT1 write out_port", outp[1], 32'hA5A53CA5);
        rd(5'd5);
        check("OUT1 readback", rdata[1], 32'h0000_003C);

        // MASK2 = 0x01, then rising edge on bit 16 before edge N
        cyc(1'b0, 1'b1, 5'd11, 32'h0000_0001);
        idle(); in_port[16] = 1'b1;               // edge N
        idle();                                   // edge N+1
        rd(5'd10);                                // edge N+2
        check("EDGE2 not yet readable", rdata[1], 32'd0);
        check("irq low at N+2", {31'd0, irq_o[1]}, 32'd0);
        rd(5'd10);                                // edge N+3
        check("EDGE2 rise captured", rdata[1], 32'h1);
        check("irq high after N+3", {31'd0, irq_o[1]}, 32'd1);
        check("EDGE2 rise ignored by fall type", rdata[2], 32'd0);
        rd(5'd16);
        check("PEND ch2", rdata[1], 32'h4);

        // W1C colliding with a fresh rising detect: set wins
        idle(); in_port[16] = 1'b0;               // edge A
        idle();                                   // A+1
        idle(); in_port[16] = 1'b1;               // A+2
        idle();                                   // A+3
        cyc(1'b0, 1'b1, 5'd10, 32'h1);            // A+4, rise detected here
        @(posedge clk);
        #1;
        check("irq during W1C collision", {31'd0, irq_o[1]}, 32'd1);
        rd(5'd10);
        check("EDGE2 survives collision", rdata[1], 32'h1);
        check("irq stays high", {31'd0, irq_o[1]}, 32'd1);

        // Clean W1C: EDGE2 clears, irq drops one cycle later
        cyc(1'b0, 1'b1, 5'd10, 32'h1);
        @(posedge clk);
        #1;
        check("irq still high at W1C edge", {31'd0, irq_o[1]}, 32'd1);
        rd(5'd10);
        check("EDGE2 cleared", rdata[1], 32'd0);
        check("irq low after W1C", {31'd0, irq_o[1]}, 32'd0);

        // Clear ch2 on every instance via PEND, then a falling edge
        cyc(1'b0, 1'b1, 5'd16, 32'h4);
        idle(); in_port[16] = 1'b0;
        idle();
        idle();
        rd(5'd10);
        check("fall captured (any)", rdata[0], 32'h1);
        check("fall ignored (rise)", rdata[1], 32'd0);
        check("fall captured (fall)", rdata[2], 32'h1);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] a;
            a = ($urandom % 8 == 0) ? 5'($urandom % 32) : 5'($urandom % 17);
            cyc(1'($urandom % 2), ($urandom % 3) == 0, a, $urandom);
            if ($urandom % 4 == 0) in_port = in_port ^ (32'd1 << ($urandom % 32));
            if ($urandom % 64 == 0) in_port = $urandom;
        end

        // Unmask everything and toggle every input so irq is high
        cyc(1'b0, 1'b1, 5'd3,  32'hFF);
        cyc(1'b0, 1'b1, 5'd7,  32'hFF);
        cyc(1'b0, 1'b1, 5'd11, 32'hFF);
        cyc(1'b0, 1'b1, 5'd15, 32'hFF);
        idle(); in_port = ~in_port;
        repeat (5) idle();
        @(posedge clk);
        #1;
        check("irq high before async reset", {31'd0, irq_o[0]}, 32'd1);

        // Asynchronous reset mid-cycle: takes effect without a clock edge
        @(posedge clk);
        #3;
        reset_reset_n = 1'b0;
        in_port       = 32'd0;
        #1;
        for (int k = 0; k < NK; k++) begin
            check("async reset irq", {31'd0, irq_o[k]}, 32'd0);
            check("async reset out_port", outp[k], 32'hA5A5A5A5);
            check("async reset rdata", rdata[k], 32'd0);
        end
        repeat (2) idle();
        @(negedge clk);
        reset_reset_n = 1'b1;
        for (int i = 0; i < 8; i += 2) begin
            rd(regs[i]);
            for (int k = 0; k < NK; k++) check("EDGE after async reset", rdata[k], 32'd0);
        end
        rd(5'd16);
        check("PEND after async reset", rdata[0], 32'd0);
        cyc(1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        check("unmapped read 31", rdata[0], 32'd0);
        idle();
        repeat (3) @(posedge clk);
        #3;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pio_bank_irq.md
Name: pio_bank_irq

Overview:
- Parametrised successor to the fixed per-colour/switch PIO ports of the Nios system.
- A bank of CHANNELS independent bidirectional PIO channels, each WIDTH bits wide, on one Avalon-MM slave.
- Per channel: 2-FF input synchroniser, edge-capture register, interrupt mask and output register. A single level interrupt is raised to the Nios.
- Sits between the Nios interconnect and board/video-path signals (RGB taps, switches).

Parameters:
- CHANNELS, 4, number of channels (1..7).
- WIDTH, 8, bits per channel (1..32).
- ADDR_W, 5, word-address width; must satisfy 2^ADDR_W > 4*CHANNELS.
- EDGE_TYPE, 0, capture condition: 0 any change, 1 rising, 2 falling.
- OUT_RESET, 0, reset value of every output register (WIDTH bits).

Ports:
- clk_clk  in  1  single clock for all logic.
- reset_reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  ADDR_W  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, fixed latency 1.
- in_port  in  CHANNELS*WIDTH  asynchronous inputs; channel c occupies [c*WIDTH +: WIDTH].
- out_port  out  CHANNELS*WIDTH  output registers, same packing.
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset (asynchronous, while reset_reset_n=0):
  - synchronisers, previous-sample, edge and mask registers = 0;
  - out_port = OUT_RESET replicated;
  - avs_readdata = 0; irq = 0.
  - Reset asserted mid-operation clears all state immediately, including pending captures. No partial write survives.
- Register map, channel c at base 4*c:
  - +0 DATA: R = synchronised input, zero-extended; W ignored.
  - +1 OUT: R/W output register; out_port reflects a write from the clock edge that samples avs_write.
  - +2 EDGE: R = capture bits; W = write-1-to-clear per bit.
  - +3 MASK: R/W per-bit interrupt enable.
  - 4*CHANNELS PEND: R bit c = |(EDGE_c & MASK_c), upper bits 0; W bit c=1 clears all EDGE_c bits.
  - Any other address: read 0, write ignored.
- Write data bits above WIDTH are ignored; reads zero-extend.
- Input path per bit: s1 <= in; s2 <= s1; prev <= s2.
  - Detect: any = s2^prev; rise = s2&~prev; fall = ~s2&prev.
  - Capture: EDGE <= EDGE | detect (sticky).
- Timing, for an in_port change set up before edge N:
  - s2 valid after edge N+1.
  - EDGE bit set at edge N+2; readable by a read issued in cycle N+3.
  - irq registered: irq <= |(all EDGE & MASK); high after edge N+3.
- Simultaneous W1C and new detect on the same bit in the same cycle: set wins, bit stays 1.
- Simultaneous EDGE W1C and PEND clear on the same channel cannot occur (one address per cycle).
- Read timing: avs_readdata is registered. It is valid the cycle after avs_read=1 and is 0 in cycles with no read in the preceding cycle.
- Read and write both asserted on the same address: the write takes effect; the read returns the pre-write value.
- Masking a pending bit drops irq one cycle after the MASK write edge. Unmasking a set bit raises irq one cycle after.
- No wait-states; every access completes in one cycle.

Test Plan:
- Reset with OUT_RESET=8'hA5, CHANNELS=4 -> out_port=32'hA5A5A5A5, irq=0; reads of all EDGE and MASK return 0.
- Write 0x3C to address 5 (ch1 OUT) -> out_port[15:8]=8'h3C on the next cycle; read of address 5 returns 0x3C; other channels unchanged.
- EDGE_TYPE=1, MASK2=0x01, toggle in_port bit 16 0->1 before edge N:
  - address 10 reads 0x01 from cycle N+3;
  - irq=1 after N+3;
  - PEND (addr 16) reads 0x4.
- Write 0x01 to address 10 in the same cycle a new rising edge is detected on bit 16 -> EDGE2 stays 0x01, irq stays 1. A clean W1C afterwards -> EDGE2=0, irq=0 one cycle later.
- Falling edge with EDGE_TYPE=1 -> no capture. Same stimulus with EDGE_TYPE=0 -> capture.
- Assert reset_reset_n=0 asynchronously while irq=1 and EDGE≠0 -> irq and all captures 0 without a clock edge; out_port returns to OUT_RESET. Read of unmapped address 31 -> 0.
